// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller state encoding, frame layout constants and
// the odd-parity helper used by both the host transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_IDLE
  } ps2_state_t;

  // start + 8 data + parity + stop/ack slot
  localparam int PS2_FRAME_BITS = 11;
  localparam int ACK_INDEX      = PS2_FRAME_BITS - 1;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-stage synchroniser for the PS/2 clock and data pins with a registered
// falling-edge flag on the clock line.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic clk_p0, clk_p1, clk_p2;
  logic data_p0, data_p1;

  // Reset to the idle (released, pulled-up) line level so no edge is seen at start-up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      clk_p2  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
      fall    <= 1'b0;
    end else begin
      clk_p0  <= clk_in;
      clk_p1  <= clk_p0;
      clk_p2  <= clk_p1;
      data_p0 <= data_in;
      data_p1 <= data_p0;
      fall    <= clk_p2 & ~clk_p1;
    end
  end

  assign clk_s  = clk_p1;
  assign data_s = data_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter using the request-to-send handshake.
// Optional watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int INHIBIT_CYCLES = 12_000,
  parameter int TIMEOUT_CYCLES = 1_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int N_W   = $clog2(PS2_FRAME_BITS + 1);

  if (CLK_HZ <= 0 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES <= INHIBIT_CYCLES) begin : g_param_check
    $error("ps2_host_tx: inconsistent timing parameters");
  end

  ps2_state_t       state, state_n;
  logic [INH_W-1:0] inh_cnt;
  logic [N_W-1:0]   n;
  logic [7:0]       byte_q;
  logic             parity_q;
  logic             data_q;
  logic             nack_q;
  logic             clk_s, data_s, fall;
  logic             inh_last;
  logic             timeout;

  ps2_line_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .clk_in  (ps2_clk_in),
    .data_in (ps2_data_in),
    .clk_s   (clk_s),
    .data_s  (data_s),
    .fall    (fall)
  );

  assign inh_last = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog;

  // Loaded on the REQ edge so the count equals cycles elapsed since REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (state == REQ) begin
      wdog <= WD_W'(1);
    end else if ((state == SHIFT || state == WAIT_IDLE) && !timeout) begin
      wdog <= wdog + WD_W'(1);
    end
  end

  assign timeout = (state == SHIFT || state == WAIT_IDLE) &&
                   (wdog == WD_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    tx_ready    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) state_n = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_last) state_n = REQ;
      end
      REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        state_n     = SHIFT;
      end
      SHIFT: begin
        ps2_data_oe = data_q;
        if (fall && n == N_W'(ACK_INDEX)) state_n = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done    = ~nack_q;
          err     = nack_q;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      ps2_data_oe = 1'b0;
      done        = 1'b0;
      err         = 1'b1;
      state_n     = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      inh_cnt <= '0;
      n       <= '0;
      data_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE:    inh_cnt <= '0;
        INHIBIT: inh_cnt <= inh_cnt + INH_W'(1);
        REQ: begin
          data_q <= 1'b1;
          n      <= '0;
        end
        SHIFT: begin
          if (fall) begin
            if (n < N_W'(8))                data_q <= ~byte_q[n[2:0]];
            else if (n == N_W'(8))          data_q <= ~parity_q;
            else if (n == N_W'(9))          data_q <= 1'b0;
            else if (n == N_W'(ACK_INDEX))  nack_q <= data_s;
            n <= n + N_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Payload capture on acceptance; no reset needed as it is only read after a load
  always_ff @(posedge clk) begin
    if (state == IDLE && tx_valid) begin
      byte_q   <= tx_data;
      parity_q <= odd_parity(tx_data);
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model and a
// scoreboard of bytes expected on the wire.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 600;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ         (100_000_000),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0, err_cnt = 0, acc_cnt = 0;
  int done_cyc = 0, err_cyc = 0, acc_cyc = 0;
  int run = 0, last_run = 0;

  always @(negedge clk) begin
    #1;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err)  begin err_cnt++;  err_cyc  = cyc; end
    if (tx_valid && tx_ready) begin acc_cnt++; acc_cyc = cyc; end
    if (ps2_clk_oe) run++;
    else if (run != 0) begin last_run = run; run = 0; end
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    int k;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    k = 0;
    while (!tx_ready && k < 400) begin @(negedge clk); k++; end
    if (!tx_ready) check("accept_wait", 32'(tx_ready), 32'd1);
    exp_q.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_request(input string tag);
    int k;
    k = 0;
    while (!(ps2_clk_in && !ps2_data_in) && k < INH + 100) begin @(negedge clk); k++; end
    check({tag, "_request"}, 32'(ps2_clk_in && !ps2_data_in), 32'd1);
  endtask

  task automatic dev_frame(input logic nack, input string tag);
    logic [9:0] bits;
    logic [7:0] e;
    int ones;
    bits = '0;
    wait_request(tag);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      if (i == 10) dev_data_low = !nack;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i < 10) bits[i] = ps2_data_in;
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = 1'b0;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    ones = $countones(e);
    check({tag, "_data"},   32'(bits[7:0]), 32'(e));
    check({tag, "_parity"}, 32'(bits[8]),   32'((ones % 2) == 0));
    check({tag, "_stop"},   32'(bits[9]),   32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!tx_ready && k < 100) begin @(negedge clk); k++; end
    check({tag, "_ready"}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    int d0, e0, a0, req_cyc, k;
    logic [7:0] junk;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_clkoe", 32'(ps2_clk_oe), 32'd0);
    check("rst_datoe", 32'(ps2_data_oe), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED acked
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    check("ed_busy", 32'(busy), 32'd1);
    dev_frame(1'b0, "ed");
    wait_ready("ed");
    check("ed_done",    32'(done_cnt - d0), 32'd1);
    check("ed_err",     32'(err_cnt - e0), 32'd0);
    check("ed_inhibit", 32'(last_run), 32'(INH + 1));

    // 0x01 acked, parity 0
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h01);
    dev_frame(1'b0, "x01");
    wait_ready("x01");
    check("x01_done", 32'(done_cnt - d0), 32'd1);
    check("x01_err",  32'(err_cnt - e0), 32'd0);

    // 0xFF nacked
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hFF);
    dev_frame(1'b1, "ff");
    wait_ready("ff");
    repeat (2) @(negedge clk);
    check("ff_err",   32'(err_cnt - e0), 32'd1);
    check("ff_done",  32'(done_cnt - d0), 32'd0);
    check("ff_ready", 32'(tx_ready), 32'd1);

    // reset in the middle of SHIFT with n = 4
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h00);
    wait_request("mid");
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    check("mid_pre_datoe", 32'(ps2_data_oe), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_clkoe", 32'(ps2_clk_oe), 32'd0);
    check("mid_datoe", 32'(ps2_data_oe), 32'd0);
    check("mid_busy",  32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_done", 32'(done_cnt - d0), 32'd0);
    check("mid_err",  32'(err_cnt - e0), 32'd0);
    if (exp_q.size() != 0) junk = exp_q.pop_front();

    d0 = done_cnt;
    start_tx(8'hF4);
    dev_frame(1'b0, "f4");
    wait_ready("f4");
    check("f4_done", 32'(done_cnt - d0), 32'd1);

    // tx_valid held high across two frames
    d0 = done_cnt; a0 = acc_cnt;
    @(negedge clk);
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    exp_q.push_back(8'hAA);
    @(negedge clk);
    tx_data = 8'h55;
    exp_q.push_back(8'h55);
    dev_frame(1'b0, "aa");
    check("aa_inhibit", 32'(last_run), 32'(INH + 1));
    k = 0;
    while (acc_cnt < a0 + 2 && k < 100) begin @(negedge clk); k++; end
    tx_valid = 1'b0;
    check("hold_accepts", 32'(acc_cnt - a0), 32'd2);
    check("hold_after_done", 32'(acc_cyc - done_cyc), 32'd1);
    dev_frame(1'b0, "x55");
    wait_ready("x55");
    check("x55_inhibit", 32'(last_run), 32'(INH + 1));
    check("hold_done", 32'(done_cnt - d0), 32'd2);

    // device never clocks
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h12);
    k = 0;
    while (!(ps2_clk_oe && ps2_data_oe) && k < INH + 50) begin @(negedge clk); k++; end
    req_cyc = cyc;
    check("tmo_req_seen", 32'(ps2_clk_oe && ps2_data_oe), 32'd1);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    k = 0;
    while (err_cnt == e0 && k < TMO + 50) begin @(negedge clk); k++; end
    @(negedge clk);
    check("tmo_err",   32'(err_cnt - e0), 32'd1);
    check("tmo_at",    32'(err_cyc - req_cyc), 32'(TMO));
    check("tmo_clkoe", 32'(ps2_clk_oe), 32'd0);
    check("tmo_datoe", 32'(ps2_data_oe), 32'd0);
    check("tmo_ready", 32'(tx_ready), 32'd1);
    check("tmo_done",  32'(done_cnt - d0), 32'd0);
`else
    repeat (TMO + 50) @(negedge clk);
    check("stuck_busy",  32'(busy), 32'd1);
    check("stuck_err",   32'(err_cnt - e0), 32'd0);
    check("stuck_clkoe", 32'(ps2_clk_oe), 32'd0);
    check("stuck_datoe", 32'(ps2_data_oe), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("stuck_recover", 32'(tx_ready), 32'd1);
`endif
    if (exp_q.size() != 0) junk = exp_q.pop_front();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
